// File: rtl/svt_input_merger.sv
// N-lane SVT input receiver: per-lane input register, polarity correction and FIFO,
// merged into one channel-tagged stream by a round-robin arbiter with a valid/re output.
module svt_input_merger #(
    parameter int unsigned   NCH      = 4,
    parameter int unsigned   DW       = 23,
    parameter int unsigned   CHW      = 2,
    parameter int unsigned   AW       = 5,
    parameter int unsigned   HOLD_THR = 24,
    parameter logic [DW-1:0] INV_MASK = 23'h666666
) (
    input  logic                 clk,
    input  logic                 reset_pulsar_n,
    input  logic [NCH*(DW+1)-1:0] data_in,
    input  logic [NCH-1:0]       ch_enable,
    input  logic                 clear_err,
    output logic [NCH-1:0]       hold,
    output logic [DW-1:0]        data_out,
    output logic [CHW-1:0]       ch_out,
    output logic                 valid,
    input  logic                 re,
    output logic [NCH-1:0]       overflow_err,
    output logic                 lost_sync_err
);

    localparam int unsigned     DEPTH     = 1 << AW;
    localparam int unsigned     LW        = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [AW:0]     FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0]     HOLD_CNT  = (AW+1)'(HOLD_THR);
    localparam logic [AW:0]     ONE_CNT   = (AW+1)'(1);
    localparam logic [LW-1:0]   LAST_LANE = LW'(NCH - 1);

    logic [NCH-1:0]  ds_q, ds_d;
    logic [DW-1:0]   d_q     [NCH];
    logic [DW-1:0]   d_d     [NCH];
    logic [AW:0]     count_q [NCH];
    logic [AW:0]     count_d [NCH];
    logic [AW-1:0]   wptr_q  [NCH];
    logic [AW-1:0]   wptr_d  [NCH];
    logic [AW-1:0]   rptr_q  [NCH];
    logic [AW-1:0]   rptr_d  [NCH];
    logic [DW-1:0]   mem_q   [NCH][DEPTH];

    logic [NCH-1:0]  hold_q, hold_d;
    logic [NCH-1:0]  ovf_q, ovf_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic [CHW-1:0]  ch_q, ch_d;
    logic            valid_q, valid_d;
    logic [LW-1:0]   rr_q, rr_d;

    logic            load;
    logic            grant_found;
    logic [LW-1:0]   grant_lane;
    logic [LW-1:0]   cand;
    logic [NCH-1:0]  pop;
    logic [NCH-1:0]  wr_req;
    logic [NCH-1:0]  wr_acc;
    logic [NCH-1:0]  ovf_new;
    logic [NCH-1:0]  full;

    // Round-robin scan starts one past the last granted lane.
    always_comb begin
        load        = ~valid_q | re;
        grant_found = 1'b0;
        grant_lane  = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            cand = LW'((32'(rr_q) + k) % NCH);
            if (!grant_found && count_q[cand] != '0) begin
                grant_found = 1'b1;
                grant_lane  = cand;
            end
        end
        pop = '0;
        if (load && grant_found) begin
            pop[grant_lane] = 1'b1;
        end
    end

    // A full lane still accepts a word when it is popped in the same cycle.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            ds_d[i]    = data_in[i*(DW+1)+DW];
            d_d[i]     = data_in[i*(DW+1) +: DW];
            wr_req[i]  = ds_q[i] & ch_enable[i];
            full[i]    = (count_q[i] == FULL_CNT);
            wr_acc[i]  = wr_req[i] & (~full[i] | pop[i]);
            ovf_new[i] = wr_req[i] & full[i] & ~pop[i];
            count_d[i] = count_q[i];
            if (wr_acc[i] && !pop[i]) begin
                count_d[i] = count_q[i] + ONE_CNT;
            end else if (!wr_acc[i] && pop[i]) begin
                count_d[i] = count_q[i] - ONE_CNT;
            end
            wptr_d[i] = wptr_q[i] + AW'(wr_acc[i]);
            rptr_d[i] = rptr_q[i] + AW'(pop[i]);
            hold_d[i] = ch_enable[i] & (count_q[i] >= HOLD_CNT);
        end
        ovf_d = (clear_err ? '0 : ovf_q) | ovf_new;
    end

    always_comb begin
        dout_d  = dout_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        rr_d    = rr_q;
        if (load) begin
            if (grant_found) begin
                dout_d  = mem_q[grant_lane][rptr_q[grant_lane]];
                ch_d    = CHW'(grant_lane);
                valid_d = 1'b1;
                rr_d    = grant_lane;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_pulsar_n) begin
        if (!reset_pulsar_n) begin
            ds_q    <= '0;
            hold_q  <= '0;
            ovf_q   <= '0;
            dout_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            rr_q    <= LAST_LANE;
            for (int unsigned i = 0; i < NCH; i++) begin
                d_q[i]     <= '0;
                count_q[i] <= '0;
                wptr_q[i]  <= '0;
                rptr_q[i]  <= '0;
            end
        end else begin
            ds_q    <= ds_d;
            hold_q  <= hold_d;
            ovf_q   <= ovf_d;
            dout_q  <= dout_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                d_q[i]     <= d_d[i];
                count_q[i] <= count_d[i];
                wptr_q[i]  <= wptr_d[i];
                rptr_q[i]  <= rptr_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NCH; i++) begin
            if (wr_acc[i]) begin
                mem_q[i][wptr_q[i]] <= d_q[i] ^ INV_MASK;
            end
        end
    end

    assign hold          = hold_q;
    assign data_out      = dout_q;
    assign ch_out        = ch_q;
    assign valid         = valid_q;
    assign overflow_err  = ovf_q;
    assign lost_sync_err = |ovf_q;

endmodule

// File: tb/tb_svt_input_merger.sv
// Self-checking bench for svt_input_merger: per-lane queue reference model of the
// input stage, FIFOs, hold, overflow and round-robin output register.
module tb_svt_input_merger;

    localparam int NCH   = 4;
    localparam int DEPTH = 32;
    localparam int THR   = 24;
    localparam logic [22:0] MASK = 23'h666666;

    logic        clk = 1'b0;
    logic        reset_pulsar_n;
    logic [95:0] data_in;
    logic [3:0]  ch_enable;
    logic        clear_err;
    logic [3:0]  hold;
    logic [22:0] data_out;
    logic [1:0]  ch_out;
    logic        valid;
    logic        re;
    logic [3:0]  overflow_err;
    logic        lost_sync_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [22:0] mq [4][$];
    logic        m_valid;
    logic [22:0] m_data;
    logic [1:0]  m_ch;
    logic [3:0]  m_hold;
    logic [3:0]  m_ovf;
    int          m_rr;
    logic [3:0]  st_ds;
    logic [22:0] st_d [4];

    always #5 clk = ~clk;

    svt_input_merger #(
        .NCH(4), .DW(23), .CHW(2), .AW(5), .HOLD_THR(24), .INV_MASK(23'h666666)
    ) dut (
        .clk(clk),
        .reset_pulsar_n(reset_pulsar_n),
        .data_in(data_in),
        .ch_enable(ch_enable),
        .clear_err(clear_err),
        .hold(hold),
        .data_out(data_out),
        .ch_out(ch_out),
        .valid(valid),
        .re(re),
        .overflow_err(overflow_err),
        .lost_sync_err(lost_sync_err)
    );

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            mq[i].delete();
            st_d[i] = '0;
        end
        st_ds   = '0;
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = '0;
        m_hold  = '0;
        m_ovf   = '0;
        m_rr    = NCH - 1;
    endtask

    // Advance one clock and update the reference model with the inputs seen at that edge.
    task automatic step();
        logic [95:0] din;
        logic [3:0]  en;
        logic        r;
        logic        clr;
        logic        load;
        int          g;
        int          pre [4];
        logic [3:0]  newovf;
        din = data_in;
        en  = ch_enable;
        r   = re;
        clr = clear_err;
        @(posedge clk);
        for (int i = 0; i < NCH; i++) pre[i] = mq[i].size();
        load = !m_valid || r;
        g = -1;
        for (int k = 1; k <= NCH; k++) begin
            if (g < 0 && pre[(m_rr + k) % NCH] > 0) g = (m_rr + k) % NCH;
        end
        if (load) begin
            if (g >= 0) begin
                m_data  = mq[g].pop_front();
                m_ch    = 2'(g);
                m_valid = 1'b1;
                m_rr    = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        newovf = '0;
        for (int i = 0; i < NCH; i++) begin
            if (st_ds[i] && en[i]) begin
                if (mq[i].size() < DEPTH) mq[i].push_back(st_d[i] ^ MASK);
                else newovf[i] = 1'b1;
            end
        end
        m_ovf = (clr ? 4'b0 : m_ovf) | newovf;
        for (int i = 0; i < NCH; i++) begin
            m_hold[i] = en[i] && (pre[i] >= THR);
            st_ds[i]  = din[i*24+23];
            st_d[i]   = din[i*24 +: 23];
        end
        cyc++;
        #1;
    endtask

    task automatic set_lane(input int i, input logic ds, input logic [22:0] d);
        data_in[i*24 +: 24] = {ds, d};
    endtask

    task automatic apply_reset();
        reset_pulsar_n = 1'b0;
        data_in   = '0;
        ch_enable = 4'hF;
        clear_err = 1'b0;
        re        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset_pulsar_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (valid !== 1'b0 || data_out !== 23'h0 || ch_out !== 2'h0 || hold !== 4'h0 ||
            overflow_err !== 4'h0 || lost_sync_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v%b d%h c%0d h%b o%b l%b want all zero",
                     valid, data_out, ch_out, hold, overflow_err, lost_sync_err);
        end
    endtask

    task automatic test_single();
        logic [2:0]  vseq;
        logic [22:0] dcap;
        logic [1:0]  ccap;
        apply_reset();
        re = 1'b1;
        vseq = '0; dcap = '0; ccap = '1;
        set_lane(0, 1'b1, 23'h0);
        for (int s = 0; s < 4; s++) begin
            step();
            set_lane(0, 1'b0, 23'h0);
            if (s < 3) vseq[s] = valid;
            if (s == 2) begin dcap = data_out; ccap = ch_out; end
            checks++;
            if (valid !== m_valid || data_out !== m_data || ch_out !== m_ch || hold !== m_hold ||
                overflow_err !== m_ovf || lost_sync_err !== (|m_ovf)) begin
                errors++;
                $display("FAIL single_model cyc=%0d got v%b d%h c%0d h%b o%b want v%b d%h c%0d h%b o%b",
                         cyc, valid, data_out, ch_out, hold, overflow_err, m_valid, m_data, m_ch, m_hold, m_ovf);
            end
        end
        checks++;
        if (vseq !== 3'b100) begin
            errors++;
            $display("FAIL single_latency got valid seq %b want 100", vseq);
        end
        checks++;
        if (dcap !== 23'h666666 || ccap !== 2'd0) begin
            errors++;
            $display("FAIL single_word got d%h c%0d want d666666 c0", dcap, ccap);
        end
    endtask

    task automatic test_all_lanes();
        int seq[$];
        logic ok;
        apply_reset();
        re = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NCH; i++) set_lane(i, 1'b1, 23'($urandom()));
            for (int s = 0; s < 8; s++) begin
                step();
                if (s == 0) data_in = '0;
                if (valid) seq.push_back(int'(ch_out));
                checks++;
                if (valid !== m_valid || data_out !== m_data || ch_out !== m_ch || hold !== m_hold ||
                    overflow_err !== m_ovf || lost_sync_err !== (|m_ovf)) begin
                    errors++;
                    $display("FAIL all_lanes_model cyc=%0d got v%b d%h c%0d h%b o%b want v%b d%h c%0d h%b o%b",
                             cyc, valid, data_out, ch_out, hold, overflow_err, m_valid, m_data, m_ch, m_hold, m_ovf);
                end
            end
        end
        ok = (seq.size() == 8);
        if (ok) for (int j = 0; j < 8; j++) if (seq[j] != j % 4) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL all_lanes_order got %0d words %p want 0,1,2,3,0,1,2,3", seq.size(), seq);
        end
    endtask

    task automatic test_fill_overflow();
        logic [22:0] sent[$];
        logic [22:0] w;
        int n;
        logic ok;
        apply_reset();
        re = 1'b0;
        for (int k = 0; k < 34; k++) begin
            w = 23'($urandom());
            sent.push_back(w);
            set_lane(2, 1'b1, w);
            step();
            checks++;
            if (valid !== m_valid || data_out !== m_data || ch_out !== m_ch || hold !== m_hold ||
                overflow_err !== m_ovf || lost_sync_err !== (|m_ovf)) begin
                errors++;
                $display("FAIL fill_model cyc=%0d got v%b d%h c%0d h%b o%b want v%b d%h c%0d h%b o%b",
                         cyc, valid, data_out, ch_out, hold, overflow_err, m_valid, m_data, m_ch, m_hold, m_ovf);
            end
        end
        set_lane(2, 1'b0, 23'h0);
        repeat (2) step();
        checks++;
        if (overflow_err !== 4'b0100 || lost_sync_err !== 1'b1 || hold !== 4'b0100) begin
            errors++;
            $display("FAIL fill_flags got o%b l%b h%b want o0100 l1 h0100", overflow_err, lost_sync_err, hold);
        end
        ok = (valid === 1'b1 && data_out === (sent[0] ^ MASK));
        re = 1'b1;
        n = 0;
        for (int s = 0; s < 40; s++) begin
            step();
            if (valid) begin
                n++;
                if (n < 34 && (data_out !== (sent[n] ^ MASK) || ch_out !== 2'd2)) ok = 1'b0;
            end
            checks++;
            if (valid !== m_valid || data_out !== m_data || ch_out !== m_ch || hold !== m_hold ||
                overflow_err !== m_ovf || lost_sync_err !== (|m_ovf)) begin
                errors++;
                $display("FAIL drain_model cyc=%0d got v%b d%h c%0d h%b o%b want v%b d%h c%0d h%b o%b",
                         cyc, valid, data_out, ch_out, hold, overflow_err, m_valid, m_data, m_ch, m_hold, m_ovf);
            end
        end
        checks++;
        if (!ok || n != 32) begin
            errors++;
            $display("FAIL fill_drain_order got %0d further words in_order=%b want 32 in_order=1", n, ok);
        end
    endtask

    task automatic test_full_pop();
        logic [22:0] w;
        logic [22:0] last;
        int n;
        apply_reset();
        re = 1'b0;
        last = '0;
        for (int k = 0; k < 34; k++) begin
            w = 23'($urandom());
            last = w;
            set_lane(3, 1'b1, w);
            step();
        end
        set_lane(3, 1'b0, 23'h0);
        re = 1'b1;
        n = 0;
        for (int s = 0; s < 40; s++) begin
            step();
            if (valid) begin n++; w = data_out; end
            checks++;
            if (valid !== m_valid || data_out !== m_data || ch_out !== m_ch || hold !== m_hold ||
                overflow_err !== m_ovf || lost_sync_err !== (|m_ovf)) begin
                errors++;
                $display("FAIL full_pop_model cyc=%0d got v%b d%h c%0d h%b o%b want v%b d%h c%0d h%b o%b",
                         cyc, valid, data_out, ch_out, hold, overflow_err, m_valid, m_data, m_ch, m_hold, m_ovf);
            end
        end
        checks++;
        if (overflow_err !== 4'b0 || n != 33 || w !== (last ^ MASK)) begin
            errors++;
            $display("FAIL full_pop got o%b words %0d last %h want o0000 words 33 last %h",
                     overflow_err, n, w, last ^ MASK);
        end
    endtask

    task automatic test_disable();
        int n;
        apply_reset();
        re = 1'b0;
        for (int k = 0; k < 30; k++) begin
            set_lane(1, 1'b1, 23'($urandom()));
            step();
        end
        set_lane(1, 1'b0, 23'h0);
        repeat (2) step();
        checks++;
        if (hold[1] !== 1'b1) begin
            errors++;
            $display("FAIL disable_pre_hold got %b want 1", hold[1]);
        end
        ch_enable[1] = 1'b0;
        for (int s = 0; s < 6; s++) begin
            set_lane(1, 1'b1, 23'($urandom()));
            step();
            if (s == 0) begin
                checks++;
                if (hold[1] !== 1'b0) begin
                    errors++;
                    $display("FAIL disable_hold got %b want 0", hold[1]);
                end
            end
        end
        set_lane(1, 1'b0, 23'h0);
        re = 1'b1;
        n = 0;
        for (int s = 0; s < 40; s++) begin
            step();
            if (valid && ch_out == 2'd1) n++;
            checks++;
            if (valid !== m_valid || data_out !== m_data || ch_out !== m_ch || hold !== m_hold ||
                overflow_err !== m_ovf || lost_sync_err !== (|m_ovf)) begin
                errors++;
                $display("FAIL disable_model cyc=%0d got v%b d%h c%0d h%b o%b want v%b d%h c%0d h%b o%b",
                         cyc, valid, data_out, ch_out, hold, overflow_err, m_valid, m_data, m_ch, m_hold, m_ovf);
            end
        end
        checks++;
        if (n != 29) begin
            errors++;
            $display("FAIL disable_drain got %0d further lane1 words want 29", n);
        end
        ch_enable = 4'hF;
    endtask

    task automatic test_clear_err();
        apply_reset();
        re = 1'b0;
        for (int k = 0; k < 36; k++) begin
            set_lane(0, 1'b1, 23'($urandom()));
            step();
        end
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        checks++;
        if (overflow_err[0] !== 1'b1 || lost_sync_err !== 1'b1) begin
            errors++;
            $display("FAIL clear_coincident got o%b l%b want o[0]=1 l1", overflow_err, lost_sync_err);
        end
        set_lane(0, 1'b0, 23'h0);
        repeat (2) step();
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        checks++;
        if (overflow_err !== 4'b0 || lost_sync_err !== 1'b0) begin
            errors++;
            $display("FAIL clear_plain got o%b l%b want o0000 l0", overflow_err, lost_sync_err);
        end
        re = 1'b1;
        for (int s = 0; s < 36; s++) begin
            step();
            checks++;
            if (valid !== m_valid || data_out !== m_data || ch_out !== m_ch || hold !== m_hold ||
                overflow_err !== m_ovf || lost_sync_err !== (|m_ovf)) begin
                errors++;
                $display("FAIL clear_model cyc=%0d got v%b d%h c%0d h%b o%b want v%b d%h c%0d h%b o%b",
                         cyc, valid, data_out, ch_out, hold, overflow_err, m_valid, m_data, m_ch, m_hold, m_ovf);
            end
        end
    endtask

    task automatic test_random();
        int re_pct;
        apply_reset();
        re_pct = 70;
        for (int s = 0; s < 800; s++) begin
            if (s % 100 == 0) re_pct = (s % 200 == 0) ? 80 : 15;
            for (int i = 0; i < NCH; i++) set_lane(i, 1'($urandom_range(1, 0)), 23'($urandom()));
            re        = ($urandom_range(99, 0) < re_pct);
            clear_err = ($urandom_range(49, 0) == 0);
            if ($urandom_range(39, 0) == 0) ch_enable = 4'($urandom());
            step();
            checks++;
            if (valid !== m_valid || data_out !== m_data || ch_out !== m_ch || hold !== m_hold ||
                overflow_err !== m_ovf || lost_sync_err !== (|m_ovf)) begin
                errors++;
                $display("FAIL random_model cyc=%0d got v%b d%h c%0d h%b o%b want v%b d%h c%0d h%b o%b",
                         cyc, valid, data_out, ch_out, hold, overflow_err, m_valid, m_data, m_ch, m_hold, m_ovf);
            end
        end
        data_in   = '0;
        clear_err = 1'b0;
        ch_enable = 4'hF;
    endtask

    task automatic test_reset_mid();
        int first_ch;
        apply_reset();
        re = 1'b0;
        for (int k = 0; k < 36; k++) begin
            set_lane(3, 1'b1, 23'($urandom()));
            step();
        end
        checks++;
        if (valid !== 1'b1 || hold[3] !== 1'b1 || overflow_err[3] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup got v%b h%b o%b want v1 h[3]=1 o[3]=1", valid, hold, overflow_err);
        end
        data_in = '0;
        reset_pulsar_n = 1'b0;
        #2;
        checks++;
        if (valid !== 1'b0 || hold !== 4'h0 || overflow_err !== 4'h0 || lost_sync_err !== 1'b0 ||
            data_out !== 23'h0 || ch_out !== 2'h0) begin
            errors++;
            $display("FAIL reset_mid_async got v%b h%b o%b l%b d%h c%0d want all zero",
                     valid, hold, overflow_err, lost_sync_err, data_out, ch_out);
        end
        @(posedge clk);
        #1;
        model_reset();
        reset_pulsar_n = 1'b1;
        re = 1'b1;
        set_lane(3, 1'b1, 23'($urandom()));
        set_lane(2, 1'b1, 23'($urandom()));
        first_ch = -1;
        for (int s = 0; s < 6; s++) begin
            step();
            if (s == 0) data_in = '0;
            if (valid && first_ch < 0) first_ch = int'(ch_out);
            checks++;
            if (valid !== m_valid || data_out !== m_data || ch_out !== m_ch || hold !== m_hold ||
                overflow_err !== m_ovf || lost_sync_err !== (|m_ovf)) begin
                errors++;
                $display("FAIL reset_mid_model cyc=%0d got v%b d%h c%0d h%b o%b want v%b d%h c%0d h%b o%b",
                         cyc, valid, data_out, ch_out, hold, overflow_err, m_valid, m_data, m_ch, m_hold, m_ovf);
            end
        end
        checks++;
        if (first_ch != 2) begin
            errors++;
            $display("FAIL reset_mid_first got lane %0d want 2", first_ch);
        end
    endtask

    initial begin
        reset_pulsar_n = 1'b0;
        data_in   = '0;
        ch_enable = 4'hF;
        clear_err = 1'b0;
        re        = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_all_lanes();
        test_fill_overflow();
        test_full_pop();
        test_disable();
        test_clear_err();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
